// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory latency model.
// Consumers: dmem_array, dmem_latency_model.
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port line storage: synchronous write, combinational index-addressed read.
// Contents are intentionally never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_latency_model.sv
// Fixed-latency data memory model: one request at a time, acked LATENCY cycles after acceptance.
// Optional macro DMEM_PROTOCOL_CHECK_EN builds a sticky protocol checker driving err_o.
module dmem_latency_model
    import dmem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam int          IDX_HI   = OFFSET_W + IDX_W - 1;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 2);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rd_data;
    logic              accept;
    logic              finish;
    logic              mem_we;

    // Only the line index matters; the remaining address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:IDX_HI+1], addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = BUSY;
            BUSY:    if (cnt_q == 8'd0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = (state_q == IDLE) && enable_i;
        finish = (state_q == BUSY) && (cnt_q == 8'd0);
        mem_we = finish && write_q;
        ack_o  = (state_q == ACK);
    end

    assign state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            data_o  <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= CNT_INIT;
                idx_q   <= addr_i[IDX_HI:OFFSET_W];
                write_q <= write_i;
                wdata_q <= data_i;
            end else if ((state_q == BUSY) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end
            // Read data lands on the same edge that enters ACK; writes leave data_o alone.
            if (finish && !write_q) begin
                data_o <= rd_data;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rd_data)
    );

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= addr_i;
        end
    end

    // The cache must hold the full request stable until ack; any slip is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if ((state_q == BUSY) &&
                     (!enable_i || (addr_i != addr_q) ||
                      (write_i != write_q) || (data_i != wdata_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_latency_model.sv
// Randomized self-checking bench for dmem_latency_model against a line-array reference model.
// A second instance with LATENCY=2 checks the back-to-back ack spacing.
module tb_dmem_latency_model;
    import dmem_pkg::*;

    localparam int LAT   = 10;
    localparam int LAT2  = 2;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic         ack;
    logic [255:0] dout;
    logic         err;
    logic [1:0]   st;

    logic [31:0]  addr2 = '0;
    logic [255:0] wdata2 = '0;
    logic         en2 = 1'b0;
    logic         write2 = 1'b0;
    logic         ack2;
    logic [255:0] dout2;
    logic         err2;
    logic [1:0]   st2;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] ref_mem [DEPTH];
    bit           known [DEPTH];
    logic [255:0] exp_dout = '0;
    logic         exp_err = 1'b0;

    always #5 clk = ~clk;

    dmem_latency_model #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
        .enable_i(enable), .write_i(write), .ack_o(ack), .data_o(dout),
        .err_o(err), .state_o(st)
    );

    dmem_latency_model #(.LATENCY(LAT2), .DEPTH(DEPTH)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr2), .data_i(wdata2),
        .enable_i(en2), .write_i(write2), .ack_o(ack2), .data_o(dout2),
        .err_o(err2), .state_o(st2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the following idle cycle.
    task automatic do_req(input logic [31:0] a, input logic we, input logic [255:0] d, input int drop_at);
        int  c;
        bit  seen;
        int  idx;
        idx = int'(a / 32) % DEPTH;
        enable = 1'b1; addr = a; write = we; wdata = d;
        @(posedge clk);
        c = 0;
        seen = 0;
        while (!seen && c < LAT + 5) begin
            @(negedge clk);
            c++;
            if (c == drop_at) enable = 1'b0;
            if (ack) seen = 1;
        end
        check("ack_seen", 256'(seen), 256'(1));
        check("ack_cycle", 256'(c), 256'(LAT));
        if (we) begin
            ref_mem[idx] = d;
            known[idx] = 1;
        end else if (known[idx]) begin
            exp_dout = ref_mem[idx];
        end
        if (we || known[idx]) check("ack_data", dout, exp_dout);
        enable = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 256'(ack), 256'(0));
        if (we || known[idx]) check("data_held", dout, exp_dout);
    endtask

    initial begin
        int          lines [8];
        logic [255:0] old_line;
        logic [255:0] a5;
        int          last;
        int          n_ack;
        int          bad_acks;
        bit          prev_ack;

        lines = '{1, 2, 3, 4, 5, 200, 511, 0};
        a5 = {32{8'hA5}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_dout", dout, 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_state", 256'(st), 256'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Read of line 1 with enable held: timing only, line contents unknown yet
        do_req(32'h0000_0020, 1'b0, '0, -1);

        // Write A5 pattern then read it back
        do_req(32'h0000_0040, 1'b1, a5, -1);
        do_req(32'h0000_0040, 1'b0, '0, -1);
        check("a5_readback", dout, a5);

        // Wrap-around: 0x4040 aliases line 2
        do_req(32'h0000_4040, 1'b1, rand_line(), -1);
        do_req(32'h0000_0040, 1'b0, '0, -1);

        // Populate the working set, then random traffic with random alias/offset bits
        foreach (lines[i]) do_req(32'(lines[i]) << 5, 1'b1, rand_line(), -1);
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 262143), 9'(lines[$urandom_range(0, 7)]), 5'($urandom_range(0, 31))};
            do_req(a, 1'($urandom_range(0, 1)), rand_line(), -1);
        end
        check("err_clean", 256'(err), 256'(0));

        // Reset five cycles into a write to 0x80 aborts it
        old_line = ref_mem[4];
        enable = 1'b1; write = 1'b1; addr = 32'h80; wdata = ~old_line;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("abort_rst_ack", 256'(ack), 256'(0));
        check("abort_rst_dout", dout, 256'(0));
        check("abort_rst_state", 256'(st), 256'(IDLE));
        exp_dout = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_acks = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (ack) bad_acks++;
        end
        check("abort_no_ack", 256'(bad_acks), 256'(0));
        do_req(32'h80, 1'b0, '0, -1);
        check("abort_old_data", dout, old_line);

        // LATENCY=2 with enable held: ack every LAT2+1 cycles, never accepted in ACK
        en2 = 1'b1;
        last = -1;
        n_ack = 0;
        prev_ack = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (prev_ack) check("l2_idle_after_ack", 256'(st2), 256'(IDLE));
            if (ack2) begin
                if (last >= 0) check("l2_ack_period", 256'(i - last), 256'(LAT2 + 1));
                last = i;
                n_ack++;
            end
            prev_ack = ack2;
        end
        en2 = 1'b0;
        check("l2_ack_count", 256'(n_ack >= 12), 256'(1));
        @(negedge clk);

        // Protocol violation: enable dropped at BUSY cycle 3; request still completes
`ifdef DMEM_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_req(32'h0000_00A0, 1'b0, '0, 3);
        check("proto_err", 256'(err), 256'(exp_err));
        do_req(32'h0000_0060, 1'b0, '0, -1);
        check("proto_err_sticky", 256'(err), 256'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_latency_model.md
DMEM_LATENCY_MODEL -- requirements
Module: dmem_latency_model

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Parameter LATENCY, default 10: cycles from request acceptance to ack_o; legal range 2..255.
REQ-003 Parameter DEPTH, default 512: number of 256-bit lines stored.
REQ-004 clk_i  input  1  clock; all state changes on rising edge.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 addr_i  input  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5]; all other bits ignored.
REQ-007 data_i  input  256  write line data.
REQ-008 enable_i  input  1  request valid, held by the cache until ack_o.
REQ-009 write_i  input  1  1 = line write, 0 = line read; sampled with enable_i.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 data_o  output  256  read line data, valid while ack_o=1, held afterwards.
REQ-012 err_o  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-013 States SHALL be IDLE, BUSY and ACK.
REQ-014 IDLE with enable_i=1 SHALL accept the request: latch index, write_i and data_i; load counter with LATENCY-2; go to BUSY.
REQ-015 BUSY SHALL decrement the counter each cycle; at counter 0 go to ACK.
REQ-016 ACK SHALL drive ack_o=1 for exactly one cycle, then return to IDLE.
REQ-017 If the request is accepted at edge T, ack_o SHALL be high in the cycle after edge T+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
REQ-018 Read: data_o SHALL be updated from the latched index on the edge entering ACK; storage SHALL be unchanged.
REQ-019 Write: the storage line SHALL be written with the latched data on the edge entering ACK; data_o SHALL hold its prior value.
REQ-020 A read issued in the IDLE cycle after a write to the same line SHALL return the new data.
REQ-021 Inputs in BUSY and ACK SHALL be ignored for function; the latched request SHALL always complete.
REQ-022 enable_i=1 in ACK SHALL NOT start a request; acceptance SHALL happen only in IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-023 Addresses outside DEPTH lines SHALL wrap modulo DEPTH.

Reset
REQ-024 Reset assertion SHALL force IDLE, ack_o=0, data_o=0, err_o=0 and counter=0.
REQ-025 Reset during BUSY SHALL abort the request: no storage write and no ack_o.
REQ-026 Storage contents SHALL NOT be reset.

Configuration
REQ-027 With DMEM_PROTOCOL_CHECK_EN defined, err_o SHALL be set while in BUSY if enable_i=0, or if addr_i, write_i or data_i differs from its latched value; err_o SHALL then stay 1 until reset.
REQ-028 Without DMEM_PROTOCOL_CHECK_EN, err_o SHALL be constant 0 and no checking logic SHALL be built.

Structure
REQ-029 Package dmem_pkg SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5 and the state enum.
REQ-030 Line storage SHALL be the sub-module dmem_array: single port, synchronous write, index-addressed read.

Verification
REQ-031 Reset, then read addr 0x0000_0020 with enable held: ack_o high exactly 10 cycles after acceptance, for 1 cycle only.
REQ-032 Write 256'hA5..A5 to 0x0000_0040; after ack, read 0x0000_0040: data_o=256'hA5..A5; ack_o each time at +10 cycles.
REQ-033 Write to 0x0000_4040 with DEPTH=512, then read 0x0000_0040: the written data is returned (wrap-around).
REQ-034 Assert rst_i=0 5 cycles into a write to 0x80, release, then read 0x80: the old data is returned and no ack_o is seen for the aborted write.
REQ-035 With DMEM_PROTOCOL_CHECK_EN, drop enable_i at BUSY cycle 3: err_o=1 and stays 1, and the request still acks at +10; without the macro, err_o stays 0.
REQ-036 LATENCY=2, with enable_i held high continuously: ack_o pulses every 3 cycles and no request is accepted in ACK.
